// File: rtl/m107_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m107_pkg
//  Description : Shared types and constants for the M107 bus arbiter/decoder:
//                memory region encoding, per-region wait states and the board
//                configuration record.
//  Revision    : 1.0 - initial registered, wait-state-aware release
// ============================================================================
package m107_pkg;

    // Memory regions selectable by the decoder; NONE doubles as the idle value.
    typedef enum logic [2:0] {
        REGION_NONE    = 3'd0,
        REGION_ROM     = 3'd1,
        REGION_RAM     = 3'd2,
        REGION_PF_VRAM = 3'd3,
        REGION_EEPROM  = 3'd4,
        REGION_BUFFER  = 3'd5,
        REGION_TIMER   = 3'd6
    } region_t;

    // Wait states per region, indexed by the region_t encoding. The eighth
    // entry covers the unused encoding so any 3-bit index stays in range.
    localparam int unsigned WAIT_CYCLES [8] = '{
        0,  // REGION_NONE
        1,  // REGION_ROM
        0,  // REGION_RAM
        2,  // REGION_PF_VRAM
        3,  // REGION_EEPROM
        1,  // REGION_BUFFER
        0,  // REGION_TIMER
        0   // unused encoding
    };

    // Board strapping: which address bits the bank registers replace, the
    // alternate video map and the debug-board timer window.
    typedef struct packed {
        logic [3:0] bank_mask;
        logic       alt_map;
        logic       debug_board;
    } board_cfg_t;

endpackage : m107_pkg
`default_nettype wire

// File: rtl/m107_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : m107_region_decode
//  Description : Combinational address classifier. Maps a latched 20-bit CPU
//                address to a region and, for ROM hits, the translated ROM
//                address (including banked-window substitution).
//  Revision    : 1.0 - initial release
// ============================================================================
module m107_region_decode
    import m107_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 4
) (
    input  logic [19:0]               i_addr,
    input  logic [NUM_BANKS*BANK_W-1:0] i_bank_q,
    input  board_cfg_t                i_board_cfg,
    output region_t                   o_region,
    output logic [19:0]               o_rom_addr
);

    logic [3:0] w_seg;
    logic       w_bank_hit;
    logic [3:0] w_bank_nib;
    logic [3:0] w_banked_seg;

    // Find the bank window (0xA0000 + i*0x10000) the address falls in, if any.
    always_comb begin
        w_seg      = i_addr[19:16];
        w_bank_hit = 1'b0;
        w_bank_nib = 4'h0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (w_seg == (4'hA + 4'(i))) begin
                w_bank_hit = 1'b1;
                w_bank_nib = 4'(i_bank_q[i*BANK_W +: BANK_W]);
            end
        end
        // Masked bits come from the bank register, the rest from the CPU.
        w_banked_seg = (w_bank_nib & i_board_cfg.bank_mask) |
                       (w_seg & ~i_board_cfg.bank_mask);
    end

    // Priority address map; rom_addr stays zero for every non-ROM region.
    always_comb begin
        o_region   = REGION_ROM;
        o_rom_addr = 20'h0;
        if (w_seg == 4'hC) begin
            o_region   = REGION_ROM;
            o_rom_addr = {4'h0, i_addr[15:0]};
        end else if (w_seg == 4'hD) begin
            o_region = REGION_PF_VRAM;
        end else if (w_seg == 4'hE) begin
            o_region = REGION_RAM;
        end else if (w_seg == 4'hF) begin
            if (i_addr[15:14] == 2'b00) begin
                o_region = REGION_EEPROM;
            end else if (i_addr[15:13] == 3'b100) begin
                o_region = REGION_BUFFER;
            end else if (i_addr[15:4] == 12'hFFF) begin
                // Reset-vector page maps onto the top of the ROM image.
                o_region   = REGION_ROM;
                o_rom_addr = {16'h7FFF, i_addr[3:0]};
            end else begin
                o_region = REGION_NONE;
            end
        end else if ((w_seg == 4'h8) && i_board_cfg.alt_map) begin
            o_region = REGION_PF_VRAM;
        end else if ((w_seg == 4'hB) && i_board_cfg.debug_board) begin
            o_region = REGION_TIMER;
        end else begin
            o_region   = REGION_ROM;
            o_rom_addr = w_bank_hit ? {w_banked_seg, i_addr[15:0]} : i_addr;
        end
    end

endmodule : m107_region_decode
`default_nettype wire

// File: rtl/m107_bus_arbiter_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : m107_bus_arbiter_decoder
//  Description : Registered M107 bus front end. Accepts one CPU request at a
//                time, decodes its region through m107_region_decode, inserts
//                the region's wait states and pulses ready for one cycle.
//                Also owns the CPU-writable ROM bank registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module m107_bus_arbiter_decoder
    import m107_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 4,
    parameter int WAIT_W    = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  board_cfg_t                        board_cfg,
    input  logic                              req,
    input  logic [19:0]                       addr,
    input  logic                              bank_wr,
    input  logic [$clog2(NUM_BANKS+1)-1:0]    bank_idx,
    input  logic [BANK_W-1:0]                 bank_din,
    output logic [NUM_BANKS*BANK_W-1:0]       bank_q,
    output region_t                           region,
    output logic [19:0]                       rom_addr,
    output logic                              busy,
    output logic                              ready
);

    // Index is one bit wider than strictly needed so out-of-range indices
    // can be presented and are dropped.
    localparam int IDX_W = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t            r_state;
    logic [19:0]       r_addr;
    region_t           r_region;
    logic [19:0]       r_rom_addr;
    logic [WAIT_W-1:0] r_wait;
    logic              r_ready;
    logic              r_busy;
    logic [BANK_W-1:0] r_bank [NUM_BANKS];

    region_t           w_region;
    logic [19:0]       w_rom_addr;
    logic [WAIT_W-1:0] w_wait_load;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            // Bank register write, independent of the request state machine.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_bank[gi] <= '0;
                end else if (bank_wr && (bank_idx == IDX_W'(gi))) begin
                    r_bank[gi] <= bank_din;
                end
            end
            assign bank_q[gi*BANK_W +: BANK_W] = r_bank[gi];
        end
    endgenerate

    m107_region_decode #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_decode (
        .i_addr      (r_addr),
        .i_bank_q    (bank_q),
        .i_board_cfg (board_cfg),
        .o_region    (w_region),
        .o_rom_addr  (w_rom_addr)
    );

    assign w_wait_load = WAIT_W'(WAIT_CYCLES[w_region]);

    // Request FSM: accept, decode, count wait states, acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= 20'h0;
            r_region   <= REGION_NONE;
            r_rom_addr <= 20'h0;
            r_wait     <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (req) begin
                        r_addr  <= addr;
                        r_busy  <= 1'b1;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_region   <= w_region;
                    r_rom_addr <= w_rom_addr;
                    r_wait     <= w_wait_load;
                    if (w_wait_load != '0) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_ACK;
                        r_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_wait <= r_wait - 1'b1;
                    if (r_wait <= WAIT_W'(1)) begin
                        r_state <= ST_ACK;
                        r_ready <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_ready    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_region   <= REGION_NONE;
                    r_rom_addr <= 20'h0;
                    r_wait     <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign region   = r_region;
    assign rom_addr = r_rom_addr;
    assign busy     = r_busy;
    assign ready    = r_ready;

endmodule : m107_bus_arbiter_decoder
`default_nettype wire
